// File: rtl/tank_ctrl_pkg.sv
// Shared types for the tank level controller: state codes, band indices,
// pump/indicator drive payload and counter sizing helpers.
package tank_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FILL  = 2'b01,
        ST_DRAIN = 2'b10,
        ST_FAULT = 2'b11
    } state_t;

    localparam int unsigned BAND_L = 0;
    localparam int unsigned BAND_M = 1;
    localparam int unsigned BAND_H = 2;
    localparam int unsigned BAND_N = 3;

    typedef struct packed {
        logic pump1;
        logic pump2;
        logic trend;
        logic alarm;
    } drive_t;

    // Bits needed to hold max_val; never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

    // Pump and indicator levels belonging to each state.
    function automatic drive_t drive_decode(input state_t st);
        drive_t d;
        d.pump1 = (st == ST_FILL);
        d.pump2 = (st == ST_DRAIN);
        d.trend = (st == ST_FILL);
        d.alarm = (st == ST_FAULT);
        return d;
    endfunction

endpackage

// File: rtl/tank_level_ctrl_lvl_avg4.sv
// Four-tap moving average of the level sample, one cycle of latency.
// Only instantiated when TANK_LVL_FILTER_EN is defined.
module lvl_avg4 #(
    parameter int unsigned LVL_W = 8
) (
    input  logic             CLK100MHZ,
    input  logic             rst,
    input  logic [LVL_W-1:0] lvl_in,
    output logic [LVL_W-1:0] lvl_avg
);

    localparam int unsigned SUM_W = LVL_W + 2;

    logic [LVL_W-1:0] tap1;
    logic [LVL_W-1:0] tap2;
    logic [LVL_W-1:0] tap3;
    logic [SUM_W-1:0] sum_c;

    assign sum_c = SUM_W'(lvl_in) + SUM_W'(tap1) + SUM_W'(tap2) + SUM_W'(tap3);

    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            tap1    <= '0;
            tap2    <= '0;
            tap3    <= '0;
            lvl_avg <= '0;
        end else begin
            tap1    <= lvl_in;
            tap2    <= tap1;
            tap3    <= tap2;
            lvl_avg <= sum_c[SUM_W-1:2];
        end
    end

endmodule

// File: rtl/tank_level_ctrl.sv
// Fill/drain pump controller with hysteresis, minimum dwell, stall watchdog
// and level band flags. Define TANK_LVL_FILTER_EN to add a 4-tap level average.
module tank_level_ctrl
    import tank_ctrl_pkg::*;
#(
    parameter int unsigned LVL_W     = 8,
    parameter int unsigned LOW_TH    = 20,
    parameter int unsigned MID_TH    = 50,
    parameter int unsigned HIGH_TH   = 90,
    parameter int unsigned MIN_DWELL = 16,
    parameter int unsigned STALL_CYC = 1000
) (
    input  logic             CLK100MHZ,
    input  logic             rst,
    input  logic [LVL_W-1:0] water_lvl,
    input  logic             fault_clr,
    output logic             pump1_ctrl,
    output logic             pump2_ctrl,
    output logic             L,
    output logic             M,
    output logic             H,
    output logic             water_trend,
    output logic             alarm,
    output logic [1:0]       state_o,
    output logic [LVL_W-1:0] water_lvl_indicator
);

    localparam int unsigned DWELL_W = cnt_width(MIN_DWELL - 1);
    localparam int unsigned STALL_W = cnt_width(STALL_CYC - 1);
`ifdef TANK_LVL_FILTER_EN
    localparam int unsigned VLD_D = 2;
`else
    localparam int unsigned VLD_D = 1;
`endif

    localparam logic [LVL_W-1:0]   LOW_LVL    = LVL_W'(LOW_TH);
    localparam logic [LVL_W-1:0]   MID_LVL    = LVL_W'(MID_TH);
    localparam logic [LVL_W-1:0]   HIGH_LVL   = LVL_W'(HIGH_TH);
    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(MIN_DWELL - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYC - 1);

    logic [LVL_W-1:0]   lvl_q;
    logic [LVL_W-1:0]   lvl_use;
    logic [VLD_D-1:0]   vld_sr;
    logic               lvl_vld;
    logic [BAND_N-1:0]  band_q;
    state_t             state;
    drive_t             drive_q;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [STALL_W-1:0] stall_cnt;
    logic [LVL_W-1:0]   ref_lvl;

    logic               progress_c;
    logic               stall_c;
    logic               turn_c;
    state_t             entry_c;
    state_t             rev_c;

    // Input sample register; vld_sr marks when the decision level is meaningful.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            lvl_q  <= '0;
            vld_sr <= '0;
        end else begin
            lvl_q  <= water_lvl;
            vld_sr <= VLD_D'({vld_sr, 1'b1});
        end
    end

    assign lvl_vld = vld_sr[VLD_D-1];

`ifdef TANK_LVL_FILTER_EN
    lvl_avg4 #(.LVL_W(LVL_W)) u_lvl_avg4 (
        .CLK100MHZ (CLK100MHZ),
        .rst       (rst),
        .lvl_in    (lvl_q),
        .lvl_avg   (lvl_use)
    );
`else
    assign lvl_use = lvl_q;
`endif

    // Band flags stay cleared until the first valid level has been seen.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            band_q <= '0;
        end else begin
            band_q[BAND_L] <= lvl_vld && (lvl_use < MID_LVL);
            band_q[BAND_M] <= lvl_vld && (lvl_use >= MID_LVL) && (lvl_use < HIGH_LVL);
            band_q[BAND_H] <= lvl_vld && (lvl_use >= HIGH_LVL);
        end
    end

    always_comb begin
        progress_c = 1'b0;
        turn_c     = 1'b0;
        rev_c      = ST_FILL;
        entry_c    = (lvl_use >= HIGH_LVL) ? ST_DRAIN : ST_FILL;
        if (state == ST_FILL) begin
            progress_c = (lvl_use > ref_lvl);
            turn_c     = (dwell_cnt == '0) && (lvl_use >= HIGH_LVL);
            rev_c      = ST_DRAIN;
        end else if (state == ST_DRAIN) begin
            progress_c = (lvl_use < ref_lvl);
            turn_c     = (dwell_cnt == '0) && (lvl_use <= LOW_LVL);
            rev_c      = ST_FILL;
        end
        stall_c = !progress_c && (stall_cnt == STALL_LAST);
    end

    // Control FSM; drive_q is loaded together with the state it belongs to.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            drive_q   <= '0;
            dwell_cnt <= '0;
            stall_cnt <= '0;
            ref_lvl   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (lvl_vld) begin
                        state     <= entry_c;
                        drive_q   <= drive_decode(entry_c);
                        dwell_cnt <= DWELL_LOAD;
                        stall_cnt <= '0;
                        ref_lvl   <= lvl_use;
                    end
                end
                ST_FILL, ST_DRAIN: begin
                    if (stall_c) begin
                        state   <= ST_FAULT;
                        drive_q <= drive_decode(ST_FAULT);
                    end else if (turn_c) begin
                        state     <= rev_c;
                        drive_q   <= drive_decode(rev_c);
                        dwell_cnt <= DWELL_LOAD;
                        stall_cnt <= '0;
                        ref_lvl   <= lvl_use;
                    end else begin
                        if (dwell_cnt != '0) begin
                            dwell_cnt <= dwell_cnt - DWELL_W'(1);
                        end
                        if (progress_c) begin
                            ref_lvl   <= lvl_use;
                            stall_cnt <= '0;
                        end else begin
                            stall_cnt <= stall_cnt + STALL_W'(1);
                        end
                    end
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        state   <= ST_IDLE;
                        drive_q <= drive_decode(ST_IDLE);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    drive_q <= '0;
                end
            endcase
        end
    end

    assign pump1_ctrl          = drive_q.pump1;
    assign pump2_ctrl          = drive_q.pump2;
    assign water_trend         = drive_q.trend;
    assign alarm               = drive_q.alarm;
    assign state_o             = state;
    assign L                   = band_q[BAND_L];
    assign M                   = band_q[BAND_M];
    assign H                   = band_q[BAND_H];
    assign water_lvl_indicator = lvl_use;

endmodule

// File: doc/tank_level_ctrl.md
Name: tank_level_ctrl

Overview:
- Parametrised successor to the single-tank pump PLC.
- Drives fill pump (pump1) and drain pump (pump2) from a sampled water level using a hysteresis FSM with configurable thresholds.
- Adds minimum pump dwell, a stall/leak watchdog with latched alarm, and registered L/M/H band flags.
- Sits between the level-sensor interface and the pump driver / indicator logic on the FPGA.

Parameters:
- LVL_W, 8, level width in bits.
- LOW_TH, 20, drain-to-fill threshold; transition when level <= LOW_TH.
- MID_TH, 50, boundary between L and M bands.
- HIGH_TH, 90, fill-to-drain threshold; transition when level >= HIGH_TH.
- MIN_DWELL, 16, minimum cycles spent in FILL/DRAIN before a direction change is allowed.
- STALL_CYC, 1000, cycles without level progress in the pumping direction before FAULT.
- Legal ranges: 0 < LOW_TH < MID_TH < HIGH_TH <= 2^LVL_W-1; MIN_DWELL >= 1; STALL_CYC > MIN_DWELL.

Ports:
- CLK100MHZ  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- water_lvl  in  LVL_W  raw level sample.
- fault_clr  in  1  single-cycle pulse; clears FAULT.
- pump1_ctrl  out  1  fill pump on.
- pump2_ctrl  out  1  drain pump on.
- L, M, H  out  1 each  level band flags, one-hot.
- water_trend  out  1  1 = filling (FILL state).
- alarm  out  1  latched fault indicator.
- state_o  out  2  FSM state code.
- water_lvl_indicator  out  LVL_W  level value used internally (lvl_q).

Behaviour:
Reset:
- Clock is CLK100MHZ. Reset rst is asynchronous and active-high.
- Reset asserts immediately, regardless of the clock.
- Reset values: state=IDLE, pumps=0, L=M=H=0, water_trend=0, alarm=0, lvl_q=0, counters=0.
- Reset mid-operation aborts any dwell or stall count. There is no memory of the previous direction.

Input path:
- water_lvl is registered into lvl_q (1 cycle).
- All decisions use lvl_q.

State encoding (state_o):
- IDLE=00, FILL=01, DRAIN=10, FAULT=11.

Transitions:
- IDLE: on the first cycle after reset release, go to DRAIN if lvl_q >= HIGH_TH, else go to FILL.
- FILL -> DRAIN: when lvl_q >= HIGH_TH and the dwell counter is 0.
- DRAIN -> FILL: when lvl_q <= LOW_TH and the dwell counter is 0.
- FILL or DRAIN -> FAULT: when the stall counter reaches STALL_CYC-1 without progress. FAULT takes priority over a threshold transition in the same cycle.
- FAULT -> IDLE: on fault_clr. In any other state fault_clr is ignored. IDLE then re-evaluates as after reset.

Dwell counter:
- Loaded with MIN_DWELL-1 on entry to FILL/DRAIN.
- Decrements to 0 and saturates there.
- A threshold crossing during dwell is held off until the counter is 0, then taken.

Stall watchdog:
- On entry to FILL/DRAIN, ref_lvl is set to lvl_q and the stall counter to 0.
- Progress in FILL means lvl_q > ref_lvl; in DRAIN, lvl_q < ref_lvl.
- On progress, ref_lvl is set to lvl_q and the counter cleared. Otherwise the counter increments.
- The counter is inactive in IDLE and FAULT.

Outputs (pumps and water_trend decode the state register; latency is 2 cycles from water_lvl to pump change):
- FILL: pump1=1, pump2=0, water_trend=1.
- DRAIN: pump1=0, pump2=1, water_trend=0.
- IDLE/FAULT: both pumps 0.
- Pumps are never both 1.
- alarm=1 exactly while in FAULT.

Bands (registered from lvl_q, asserted one cycle after lvl_q; all 0 in IDLE after reset):
- L when lvl_q < MID_TH.
- M when MID_TH <= lvl_q < HIGH_TH.
- H when lvl_q >= HIGH_TH.

Boundaries:
- lvl_q at 0 or at maximum is handled by the same comparisons; no wrap arithmetic on the level.
- Counter widths use $clog2 of their maxima; counters never wrap.

Optional Feature:
- Macro: TANK_LVL_FILTER_EN.
- Defined: a 4-tap moving average is inserted after lvl_q.
  - Sum width is LVL_W+2; the result is truncated >>2.
  - Taps reset to 0.
  - Adds 1 cycle of latency (water_lvl to pump change = 3 cycles).
  - The filtered value drives the FSM, bands and water_lvl_indicator.
- Undefined: lvl_q is used directly; latency is 2 cycles.

Decomposition:
- Package tank_ctrl_pkg holds:
  - state encoding constants: ST_IDLE, ST_FILL, ST_DRAIN, ST_FAULT;
  - band index constants;
  - a function computing counter width.
- One natural sub-module: lvl_avg4, the moving-average filter, parametrised by LVL_W, instantiated only under TANK_LVL_FILTER_EN.

Test Plan:
- Reset release with water_lvl=10 -> IDLE for 1 cycle, then FILL: pump1=1, pump2=0, L=1, water_trend=1.
- Ramp water_lvl 10->95 at +1 every 4 cycles -> M rises when lvl_q=50; DRAIN entered once lvl_q=90 (pump2=1 two cycles after water_lvl=90); H=1.
- In DRAIN, drop water_lvl to 20 only 5 cycles after entering DRAIN -> FILL is delayed until the 16-cycle dwell expires, then entered.
- In FILL, hold water_lvl constant at 40 for 1000 cycles -> FAULT: alarm=1, both pumps 0, state_o=11. A fault_clr pulse -> IDLE, then FILL.
- Assert rst asynchronously mid-DRAIN (between clock edges) -> pumps, bands and alarm go 0 immediately; after release with water_lvl=92 -> DRAIN.
- With TANK_LVL_FILTER_EN: step water_lvl 0->100 -> filtered level reads 25, 50, 75, 100 on successive cycles; DRAIN is entered only after the filtered value reaches >= 90.
